// File: rtl/id_ex_stage_if.sv
// Purpose: bundles the ID-side inputs and EX-side registered outputs of the ID/EX pipeline register.
// Ports:   id_* (decoded instruction + controls), flush_i/hold_i (pipeline control),
//          ex_* (registered stage contents), stall_o (freeze PC, IF/ID), bubble_cnt_o (load-use bubbles).
interface id_ex_stage_if #(
  parameter int DW = 32
);
  // ID side
  logic          id_valid_i;
  logic [DW-1:0] id_pc4_i;
  logic [DW-1:0] id_rd1_i;
  logic [DW-1:0] id_rd2_i;
  logic [DW-1:0] id_imm_i;
  logic [4:0]    id_rs_i;
  logic [4:0]    id_rt_i;
  logic [4:0]    id_rd_i;
  logic          id_regwrite_i;
  logic          id_memtoreg_i;
  logic          id_memread_i;
  logic          id_memwrite_i;
  logic          id_branch_i;
  logic          id_alusrc_i;
  logic          id_regdst_i;
  logic [1:0]    id_aluop_i;

  // pipeline control
  logic          flush_i;
  logic          hold_i;

  // EX side
  logic          ex_valid_o;
  logic [DW-1:0] ex_pc4_o;
  logic [DW-1:0] ex_rd1_o;
  logic [DW-1:0] ex_rd2_o;
  logic [DW-1:0] ex_imm_o;
  logic [4:0]    ex_rs_o;
  logic [4:0]    ex_rt_o;
  logic [4:0]    ex_rd_o;
  logic          ex_regwrite_o;
  logic          ex_memtoreg_o;
  logic          ex_memread_o;
  logic          ex_memwrite_o;
  logic          ex_branch_o;
  logic          ex_alusrc_o;
  logic          ex_regdst_o;
  logic [1:0]    ex_aluop_o;

  logic          stall_o;
  logic [15:0]   bubble_cnt_o;

  // master: the decode stage / environment driving ID and observing EX
  modport master (
    output id_valid_i, id_pc4_i, id_rd1_i, id_rd2_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i,
           id_regwrite_i, id_memtoreg_i, id_memread_i, id_memwrite_i, id_branch_i,
           id_alusrc_i, id_regdst_i, id_aluop_i, flush_i, hold_i,
    input  ex_valid_o, ex_pc4_o, ex_rd1_o, ex_rd2_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o,
           ex_regwrite_o, ex_memtoreg_o, ex_memread_o, ex_memwrite_o, ex_branch_o,
           ex_alusrc_o, ex_regdst_o, ex_aluop_o, stall_o, bubble_cnt_o
  );

  // slave: the ID/EX register itself
  modport slave (
    input  id_valid_i, id_pc4_i, id_rd1_i, id_rd2_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i,
           id_regwrite_i, id_memtoreg_i, id_memread_i, id_memwrite_i, id_branch_i,
           id_alusrc_i, id_regdst_i, id_aluop_i, flush_i, hold_i,
    output ex_valid_o, ex_pc4_o, ex_rd1_o, ex_rd2_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o,
           ex_regwrite_o, ex_memtoreg_o, ex_memread_o, ex_memwrite_o, ex_branch_o,
           ex_alusrc_o, ex_regdst_o, ex_aluop_o, stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// Purpose: ID/EX pipeline register with load-use hazard detection, bubble insertion and bubble counter.
// Latency: 1 cycle ID->EX; stall_o/hazard are combinational from EX state and ID indices.
// Ports:   clk, rst_n (async active-low), bus (id_ex_stage_if.slave: id_*, flush_i, hold_i in; ex_*, stall_o, bubble_cnt_o out).
module id_ex_stage #(
  parameter int DW = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic [1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic          valid;
    ctrl_t         ctrl;
    logic [DW-1:0] pc4;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
  } stage_t;

  stage_t      ex_q, ex_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  ctrl_t       id_ctrl;
  logic        hazard;

  assign id_ctrl = '{
    regwrite: bus.id_regwrite_i,
    memtoreg: bus.id_memtoreg_i,
    memread:  bus.id_memread_i,
    memwrite: bus.id_memwrite_i,
    branch:   bus.id_branch_i,
    alusrc:   bus.id_alusrc_i,
    regdst:   bus.id_regdst_i,
    aluop:    bus.id_aluop_i
  };

  // A load in EX whose destination is a source of the ID instruction cannot
  // forward in time. Register $0 is hard-wired zero, so it is never a dependency.
  assign hazard = ex_q.valid & ex_q.ctrl.memread & bus.id_valid_i & (ex_q.rt != 5'd0) &
                  ((ex_q.rt == bus.id_rs_i) | (ex_q.rt == bus.id_rt_i));

  // Flush kills whatever would otherwise be frozen, so it also releases the stall.
  assign bus.stall_o = ~bus.flush_i & (bus.hold_i | hazard);

  // Priority: flush > hold > hazard (bubble) > normal load.
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.flush_i) begin
      ex_d = '0;
    end else if (bus.hold_i) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
      if (bubble_cnt_q != 16'hFFFF) begin
        bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
    end else begin
      ex_d.valid = bus.id_valid_i;
      // Controls only travel with a valid instruction; data is captured regardless.
      ex_d.ctrl  = bus.id_valid_i ? id_ctrl : '0;
      ex_d.pc4   = bus.id_pc4_i;
      ex_d.rd1   = bus.id_rd1_i;
      ex_d.rd2   = bus.id_rd2_i;
      ex_d.imm   = bus.id_imm_i;
      ex_d.rs    = bus.id_rs_i;
      ex_d.rt    = bus.id_rt_i;
      ex_d.rd    = bus.id_rd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_valid_o    = ex_q.valid;
  assign bus.ex_pc4_o      = ex_q.pc4;
  assign bus.ex_rd1_o      = ex_q.rd1;
  assign bus.ex_rd2_o      = ex_q.rd2;
  assign bus.ex_imm_o      = ex_q.imm;
  assign bus.ex_rs_o       = ex_q.rs;
  assign bus.ex_rt_o       = ex_q.rt;
  assign bus.ex_rd_o       = ex_q.rd;
  assign bus.ex_regwrite_o = ex_q.ctrl.regwrite;
  assign bus.ex_memtoreg_o = ex_q.ctrl.memtoreg;
  assign bus.ex_memread_o  = ex_q.ctrl.memread;
  assign bus.ex_memwrite_o = ex_q.ctrl.memwrite;
  assign bus.ex_branch_o   = ex_q.ctrl.branch;
  assign bus.ex_alusrc_o   = ex_q.ctrl.alusrc;
  assign bus.ex_regdst_o   = ex_q.ctrl.regdst;
  assign bus.ex_aluop_o    = ex_q.ctrl.aluop;
  assign bus.bubble_cnt_o  = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width of operands, immediate and PC.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports id_valid_i  input  1, id_pc4_i  input  DW, id_rd1_i  input  DW, id_rd2_i  input  DW, id_imm_i  input  DW (sign-extended immediate), id_rs_i/id_rt_i/id_rd_i  input  5 each.
REQ-005 SHALL have control inputs id_regwrite_i, id_memtoreg_i, id_memread_i, id_memwrite_i, id_branch_i, id_alusrc_i, id_regdst_i (1 each) and id_aluop_i (2).
REQ-006 SHALL have flush_i  input  1 (branch taken, kill ID/EX content) and hold_i  input  1 (downstream stall, freeze EX).
REQ-007 SHALL have outputs ex_valid_o, ex_pc4_o, ex_rd1_o, ex_rd2_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o and ex_* counterparts of every REQ-005 control, same widths, all registered.
REQ-008 SHALL have stall_o  output  1  (freeze PC and IF/ID) and bubble_cnt_o  output  16  (inserted load-use bubbles).

Function
REQ-009 SHALL compute hazard = ex_valid_o & ex_memread_o & id_valid_i & (ex_rt_o != 0) & (ex_rt_o == id_rs_i | ex_rt_o == id_rt_i), combinationally.
REQ-010 SHALL drive stall_o = ~flush_i & (hold_i | hazard), combinationally.
REQ-011 SHALL apply per-edge priority: flush_i > hold_i > hazard > normal load.
REQ-012 flush_i=1: SHALL clear ex_valid_o, all ex_* controls and all data/index fields to 0 on the next edge.
REQ-013 hold_i=1 (no flush): SHALL retain every ex_* register unchanged; bubble_cnt_o unchanged.
REQ-014 hazard=1 (no flush, no hold): SHALL load a bubble -- ex_valid_o=0, all controls 0, data/index fields 0 -- and increment bubble_cnt_o.
REQ-015 Normal load: SHALL capture all id_* inputs into ex_* in one cycle (latency 1); ex_valid_o=id_valid_i.
REQ-016 id_valid_i=0 on normal load: SHALL force all captured controls to 0 (data fields still captured).
REQ-017 bubble_cnt_o SHALL saturate at 16'hFFFF, never wrapping.
REQ-018 Only ex_valid_o=1 entries SHALL ever present a nonzero control; any write/memory control implies valid.
REQ-019 A load-use pair SHALL cost exactly one bubble: after the bubble, EX holds no load, so hazard deasserts and the held ID instruction loads next unblocked edge.
REQ-020 hazard simultaneous with hold_i: SHALL hold, not bubble; bubble inserted on first edge with hold_i=0 if hazard persists.
REQ-021 Register $0 (rt==0) SHALL never cause a hazard.

Reset
REQ-022 rst_n=0 SHALL immediately (asynchronously) set every ex_* output, ex_valid_o and bubble_cnt_o to 0; stall_o then evaluates to 0 unless hold_i=1.
REQ-023 Deassertion of rst_n SHALL take effect at the first rising clk edge after release; reset asserted mid-hold or mid-bubble SHALL discard that state.

Verification
REQ-024 Normal flow: id_valid=1, rd1=32'h11, imm=32'hFFFF_FFFC, regwrite=1 -> next edge ex_rd1=32'h11, ex_imm=32'hFFFF_FFFC, ex_regwrite=1, ex_valid=1, stall_o=0.
REQ-025 Load-use: EX holds lw rt=5 (memread=1,valid=1), ID add rs=5 -> stall_o=1 same cycle; next edge ex_valid=0, ex_regwrite=0, bubble_cnt=1; following edge add enters EX, stall_o=0.
REQ-026 $0 exemption: EX lw rt=0, ID rs=0 -> stall_o=0, no bubble, bubble_cnt unchanged.
REQ-027 Flush beats hazard/hold: hazard=1, hold_i=1, flush_i=1 -> stall_o=0; next edge all ex_* =0, bubble_cnt unchanged.
REQ-028 Hold: hold_i=1 for 3 cycles with changing id_* -> ex_* constant, stall_o=1; hold drops -> current id_* captured next edge.
REQ-029 Async reset + saturation: preset bubble_cnt to 16'hFFFF via 65535 bubbles, one more hazard -> stays 16'hFFFF; rst_n low between edges -> all outputs 0 before next edge.
